uart_apb_ctrl: RTL and testbench
================================

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning the maximum ACCESS-phase wait cycles on a DATA write while tx_full=1.
REQ-002 SHALL provide PCLK, input, 1, the only clock; all logic is rising-edge.
REQ-003 SHALL provide PRESET, input, 1, synchronous active-high reset.
REQ-004 SHALL provide APB slave inputs:
- PSEL, 1
- PENABLE, 1
- PWRITE, 1
- PADDR, 32
- PWDATA, 32
REQ-005 SHALL provide APB slave outputs:
- PRDATA, 32
- PREADY, 1
- PSLVERR, 1
REQ-006 SHALL provide UART-side outputs:
- wr_uart, 1, one-cycle push pulse.
- rd_uart, 1, one-cycle pop pulse.
- w_data, 8, TX byte.
REQ-007 SHALL provide UART-side inputs:
- r_data, 8, RX FIFO head byte (first-word-fall-through).
- tx_full, 1.
- rx_empty, 1.
REQ-008 SHALL provide irq, output, 1, level interrupt.

Function
REQ-009 SHALL decode only PADDR[7:0]:
- 0x00 DATA
- 0x04 STATUS
- 0x08 CTRL
- any other offset is unmapped.
REQ-010 FSM states SHALL be IDLE, ACCESS, WAIT_TX.
- IDLE->ACCESS on PSEL=1 & PENABLE=0 (SETUP); address, direction and PWDATA[7:0] are latched at this edge.
REQ-011 ACCESS, no stall condition: SHALL drive PREADY=1 for exactly one cycle, then return to IDLE, or to ACCESS if a new SETUP is present.
REQ-012 DATA write, tx_full=0 in ACCESS: SHALL assert PREADY=1 and wr_uart=1 in the same cycle, with w_data = latched PWDATA[7:0].
REQ-013 DATA write, tx_full=1 in ACCESS: SHALL go to WAIT_TX with PREADY=0.
- Load wait counter with 0; increment every cycle in WAIT_TX.
REQ-014 WAIT_TX, tx_full falls: SHALL complete on that cycle with PREADY=1, wr_uart=1, PSLVERR=0.
REQ-015 WAIT_TX, counter reaches TIMEOUT while still full: SHALL complete with PREADY=1, PSLVERR=1, wr_uart=0.
- Byte dropped.
- Set sticky STATUS.TXERR.
- If tx_full falls on the same cycle as the counter reaches TIMEOUT, tx_full takes priority (REQ-014).
REQ-016 DATA read, rx_empty=0: SHALL complete zero-wait with PRDATA={24'h0,r_data}, PREADY=1, rd_uart=1 in the same cycle.
REQ-017 DATA read, rx_empty=1: SHALL complete zero-wait with PRDATA=0, PSLVERR=1, rd_uart=0, and set sticky STATUS.RXERR.
REQ-018 STATUS read SHALL return [0]=rx_empty, [1]=tx_full, [2]=TXERR, [3]=RXERR, [31:4]=0.
REQ-019 STATUS write SHALL be write-1-to-clear on bits [3:2]; other bits are ignored.
- If a set event and a clear hit the same bit in the same cycle, set wins.
REQ-020 CTRL SHALL be read/write:
- [0] RXIE
- [1] TXIE
- [2] ERRIE
- [31:3] read 0.
REQ-021 Unmapped offset SHALL complete zero-wait with PSLVERR=1, PRDATA=0, no register or UART side effect.
REQ-022 irq SHALL be registered, updated every cycle as (RXIE & ~rx_empty) | (TXIE & ~tx_full) | (ERRIE & (TXERR|RXERR)).
REQ-023 wr_uart and rd_uart SHALL never assert together, and each SHALL assert at most one cycle per transfer.
REQ-024 PRDATA SHALL be 0 whenever PREADY=0 or no read is completing; PSLVERR SHALL be 0 except on a completing cycle.
REQ-025 PSEL dropping mid-transfer (protocol violation) SHALL return the FSM to IDLE next cycle with no UART pulse.

Reset
REQ-026 While PRESET=1 at a PCLK edge:
- FSM=IDLE, counter=0, CTRL=0, TXERR=RXERR=0.
- PREADY=0, PSLVERR=0, PRDATA=0, wr_uart=0, rd_uart=0, w_data=0, irq=0.
REQ-027 Reset asserted during WAIT_TX SHALL abort the transfer with no wr_uart pulse.
- The first SETUP after reset is accepted on the first cycle PRESET=0.

Verification
REQ-028 Write DATA=0x000000A5, tx_full=0 -> ACCESS cycle shows PREADY=1, wr_uart=1, w_data=0xA5, PSLVERR=0.
REQ-029 Write DATA=0x3C with tx_full=1, released after 10 cycles -> 10 wait cycles with PREADY=0, then PREADY=1 and wr_uart=1, w_data=0x3C.
REQ-030 Write DATA with tx_full held high, TIMEOUT=255 -> PREADY=1 and PSLVERR=1 after 255 wait cycles, no wr_uart, STATUS read returns 0x5 (TXERR set, rx_empty=1).
REQ-031 Read DATA with r_data=0x7E, rx_empty=0 -> PRDATA=0x7E, rd_uart=1 single cycle; read again with rx_empty=1 -> PRDATA=0, PSLVERR=1, RXERR set.
REQ-032 Write CTRL=0x1, drive rx_empty 1->0 -> irq=1 one cycle later; write STATUS=0xC -> TXERR and RXERR cleared.
REQ-033 Write offset 0x10 -> PSLVERR=1, zero-wait, CTRL unchanged; assert PRESET during WAIT_TX -> all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_apb_ctrl_if.sv
// uart_apb_ctrl_if: APB slave bus bundle between a bus master and uart_apb_ctrl
interface uart_apb_ctrl_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB slave exposing DATA/STATUS/CTRL registers in front of a UART TX/RX FIFO pair
module uart_apb_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic           PCLK,
  input  logic           PRESET,
  uart_apb_ctrl_if.slave apb,
  output logic           wr_uart,
  output logic           rd_uart,
  output logic [7:0]     w_data,
  input  logic [7:0]     r_data,
  input  logic           tx_full,
  input  logic           rx_empty,
  output logic           irq
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_TX} state_t;
  state_t st;
  logic [7:0] addr;
  logic wr;
  logic [CW-1:0] cnt;
  logic [2:0] ctrl;
  logic txerr, rxerr;
  logic setup, busy, dat, sta, ctl, tmo, done, err;
  logic [31:0] rdata;
  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[31:8], apb.PWDATA[31:8]};
  // The ACCESS cycle itself is the first wait cycle, so WAIT_TX gives up after TIMEOUT-1 more
  always_comb begin
    setup = apb.PSEL & ~apb.PENABLE;
    busy = ~PRESET & apb.PSEL & (st != IDLE);
    dat = addr == 8'h00;
    sta = addr == 8'h04;
    ctl = addr == 8'h08;
    tmo = cnt == CW'(TIMEOUT - 1);
    done = busy & (st == WAIT_TX ? ~tx_full | tmo : ~(dat & wr & tx_full));
    err = ~(dat | sta | ctl) | (dat & ~wr & rx_empty) | ((st == WAIT_TX) & tx_full);
    rdata = dat ? (rx_empty ? 32'h0 : {24'h0, r_data}) :
            sta ? {28'h0, rxerr, txerr, tx_full, rx_empty} :
            ctl ? {29'h0, ctrl} : 32'h0;
    apb.PREADY = done;
    apb.PSLVERR = done & err;
    apb.PRDATA = (done & ~wr) ? rdata : 32'h0;
    wr_uart = done & dat & wr & ~tx_full;
    rd_uart = done & dat & ~wr & ~rx_empty;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      st <= IDLE;
      addr <= 8'h0;
      wr <= 1'b0;
      w_data <= 8'h0;
      cnt <= '0;
      ctrl <= 3'h0;
      txerr <= 1'b0;
      rxerr <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & ~tx_full) | (ctrl[2] & (txerr | rxerr));
      txerr <= (done & dat & wr & tx_full) | (txerr & ~(done & sta & wr & w_data[2]));
      rxerr <= (done & dat & ~wr & rx_empty) | (rxerr & ~(done & sta & wr & w_data[3]));
      if (done & ctl & wr) ctrl <= w_data[2:0];
      if (busy & ~done) begin
        st <= WAIT_TX;
        cnt <= (st == ACCESS) ? '0 : cnt + 1'b1;
      end else if (setup) begin
        st <= ACCESS;
        addr <= apb.PADDR[7:0];
        wr <= apb.PWRITE;
        w_data <= apb.PWDATA[7:0];
      end else begin
        st <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl: vector table plus hand sequences, completions checked through a scoreboard queue
module tb_uart_apb_ctrl;
  typedef struct packed {logic [31:0] rdata; logic err; logic wr; logic rd; logic [7:0] wd;} exp_t;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic txf; logic rxe; logic [7:0] rd8; exp_t e;} vec_t;
  localparam int NV = 18;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic wr_uart, rd_uart, irq;
  logic tx_full = 1'b0;
  logic rx_empty = 1'b1;
  logic [7:0] w_data;
  logic [7:0] r_data = 8'h0;
  int checks = 0;
  int errors = 0;
  int done_n = 0;
  int w8;
  exp_t sb[$];
  vec_t v[NV];
  uart_apb_ctrl_if apb ();
  uart_apb_ctrl #(.TIMEOUT(255)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb), .wr_uart(wr_uart), .rd_uart(rd_uart),
    .w_data(w_data), .r_data(r_data), .tx_full(tx_full), .rx_empty(rx_empty), .irq(irq)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask
  function automatic exp_t ex(input logic [31:0] rdata, input logic err, input logic wr, input logic rd, input logic [7:0] wd);
    return {rdata, err, wr, rd, wd};
  endfunction
  function automatic logic [63:0] outs();
    return 64'({apb.PREADY, apb.PSLVERR, apb.PRDATA, wr_uart, rd_uart, w_data, irq});
  endfunction
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input exp_t e,
                      input int rel, input int lim, output int waits);
    sb.push_back(e);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = w; apb.PADDR = a; apb.PWDATA = d;
    tick();
    apb.PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (apb.PREADY || waits > lim) break;
      waits++;
      tick();
      if (waits == rel) tx_full = 1'b0;
    end
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask
  always @(negedge PCLK) begin
    exp_t e, a;
    if (!PRESET) begin
      chk("bus_rule", 64'((wr_uart & rd_uart) | ((wr_uart | rd_uart | apb.PSLVERR | (|apb.PRDATA)) & ~apb.PREADY)), 64'd0);
      if (apb.PREADY) begin
        done_n++;
        chk("expected_done", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          a = {apb.PRDATA, apb.PSLVERR, wr_uart, rd_uart, e.wr ? w_data : e.wd};
          chk($sformatf("xfer%0d", done_n), 64'(a), 64'(e));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h0; apb.PWDATA = 32'h0;
    v[0]  = '{1'b1, 32'h00,  32'hA5,       1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b1, 1'b0, 8'hA5)};
    v[1]  = '{1'b0, 32'h04,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h1, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[2]  = '{1'b0, 32'h04,  32'h0,        1'b1, 1'b0, 8'h00, ex(32'h2, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[3]  = '{1'b0, 32'h00,  32'h0,        1'b0, 1'b0, 8'h7E, ex(32'h7E, 1'b0, 1'b0, 1'b1, 8'h00)};
    v[4]  = '{1'b0, 32'h00,  32'h0,        1'b0, 1'b1, 8'h7E, ex(32'h0, 1'b1, 1'b0, 1'b0, 8'h00)};
    v[5]  = '{1'b0, 32'h04,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h9, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[6]  = '{1'b1, 32'h08,  32'hFFFFFFFF, 1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[7]  = '{1'b0, 32'h08,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h7, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[8]  = '{1'b1, 32'h10,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h0, 1'b1, 1'b0, 1'b0, 8'h00)};
    v[9]  = '{1'b0, 32'h08,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h7, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[10] = '{1'b0, 32'h0C,  32'h0,        1'b0, 1'b0, 8'h55, ex(32'h0, 1'b1, 1'b0, 1'b0, 8'h00)};
    v[11] = '{1'b1, 32'h04,  32'h4,        1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[12] = '{1'b0, 32'h04,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h9, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[13] = '{1'b1, 32'h04,  32'hC,        1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[14] = '{1'b0, 32'h04,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h1, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[15] = '{1'b1, 32'h08,  32'h0,        1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[16] = '{1'b0, 32'h104, 32'h0,        1'b0, 1'b1, 8'h00, ex(32'h1, 1'b0, 1'b0, 1'b0, 8'h00)};
    v[17] = '{1'b1, 32'h00,  32'hFFFFFF5A, 1'b0, 1'b1, 8'h00, ex(32'h0, 1'b0, 1'b1, 1'b0, 8'h5A)};
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_outputs", outs(), 64'd0);
    tick();
    PRESET = 1'b0;
    for (int i = 0; i < NV; i++) begin
      tx_full = v[i].txf; rx_empty = v[i].rxe; r_data = v[i].rd8;
      xfer(v[i].w, v[i].a, v[i].d, v[i].e, -1, 5, w8);
      chk($sformatf("vec%0d_waits", i), 64'(w8), 64'd0);
    end
    tx_full = 1'b1; rx_empty = 1'b1;
    xfer(1'b1, 32'h0, 32'h3C, ex(32'h0, 1'b0, 1'b1, 1'b0, 8'h3C), 10, 300, w8);
    chk("stall_release_waits", 64'(w8), 64'd10);
    tx_full = 1'b1;
    xfer(1'b1, 32'h0, 32'h77, ex(32'h0, 1'b1, 1'b0, 1'b0, 8'h00), -1, 300, w8);
    chk("timeout_waits", 64'(w8), 64'd255);
    tx_full = 1'b0;
    xfer(1'b0, 32'h4, 32'h0, ex(32'h5, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    xfer(1'b1, 32'h4, 32'hC, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    xfer(1'b0, 32'h4, 32'h0, ex(32'h1, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    xfer(1'b1, 32'h8, 32'h1, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    @(negedge PCLK);
    chk("irq_rx_idle", 64'(irq), 64'd0);
    tick();
    rx_empty = 1'b0;
    @(negedge PCLK);
    chk("irq_rx_lag", 64'(irq), 64'd0);
    @(negedge PCLK);
    chk("irq_rx_set", 64'(irq), 64'd1);
    tick();
    rx_empty = 1'b1;
    xfer(1'b1, 32'h8, 32'h4, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    xfer(1'b0, 32'h0, 32'h0, ex(32'h0, 1'b1, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    repeat (2) @(negedge PCLK);
    chk("irq_err_set", 64'(irq), 64'd1);
    tick();
    xfer(1'b1, 32'h4, 32'hC, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    repeat (2) @(negedge PCLK);
    chk("irq_err_clear", 64'(irq), 64'd0);
    tick();
    xfer(1'b1, 32'h8, 32'h2, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    repeat (2) @(negedge PCLK);
    chk("irq_tx_set", 64'(irq), 64'd1);
    tick();
    xfer(1'b1, 32'h8, 32'h0, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    tx_full = 1'b1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 32'h0; apb.PWDATA = 32'h99;
    tick();
    apb.PENABLE = 1'b1;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; tx_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk($sformatf("psel_drop_wr%0d", i), 64'(wr_uart), 64'd0);
    end
    tick();
    xfer(1'b1, 32'h0, 32'h11, ex(32'h0, 1'b0, 1'b1, 1'b0, 8'h11), -1, 5, w8);
    chk("after_drop_waits", 64'(w8), 64'd0);
    tx_full = 1'b1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 32'h0; apb.PWDATA = 32'h42;
    tick();
    apb.PENABLE = 1'b1;
    repeat (3) tick();
    PRESET = 1'b1; tx_full = 1'b0;
    @(negedge PCLK);
    chk("reset_abort_wr", 64'(wr_uart), 64'd0);
    @(negedge PCLK);
    chk("reset_wait_outputs", outs(), 64'd0);
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; PRESET = 1'b0;
    xfer(1'b0, 32'h8, 32'h0, ex(32'h0, 1'b0, 1'b0, 1'b0, 8'h00), -1, 5, w8);
    chk("first_setup_waits", 64'(w8), 64'd0);
    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
